layer13_global_avgpool: RTL and testbench



---
 rtl/layer13_global_avgpool.sv | 164 ++++++++++++++++
 tb/tb_layer13_global_avgpool.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/layer13_global_avgpool.sv
// rtl/layer13_global_avgpool.sv - global average pooling of a PIX x CH activation frame
// Accumulates one sum per channel over all pixels, then streams one rounded average per channel.
module layer13_global_avgpool #(
  parameter int CH    = 1024,
  parameter int CW    = 10,
  parameter int PIX   = 49,
  parameter int PW    = 6,
  parameter int ACCW  = 14,
  parameter int RECIP = 1337,
  parameter int SHIFT = 16
) (
  input  logic       ap_clk,
  input  logic       ap_rst_n,
  input  logic [7:0] reluRes_V_V_TDATA,
  input  logic       reluRes_V_V_TVALID,
  output logic       reluRes_V_V_TREADY,
  output logic [7:0] poolRes_V_V_TDATA,
  output logic       poolRes_V_V_TVALID,
  input  logic       poolRes_V_V_TREADY
);

  localparam logic [0:0] ACCUM = 1'b0;
  localparam logic [0:0] EMIT  = 1'b1;

  localparam int              PRODW    = ACCW + 11;
  localparam logic [CW-1:0]   CH_LAST  = CW'(CH - 1);
  localparam logic [PW-1:0]   PIX_LAST = PW'(PIX - 1);
  localparam logic [CW:0]     CH_COUNT = (CW + 1)'(CH);
  localparam logic [PRODW-1:0] RECIP_W = PRODW'(RECIP);
  localparam logic [PRODW-1:0] ROUND_W = PRODW'(1) << (SHIFT - 1);

  logic [0:0]      state;
  logic            in_ready;
  logic            out_valid;
  logic [7:0]      out_data;
  logic [CW-1:0]   ch;
  logic [PW-1:0]   pix;

  logic            s1_valid;
  logic            s1_first;
  logic [CW-1:0]   s1_ch;
  logic [7:0]      s1_data;

  logic [ACCW-1:0] acc_mem [CH];
  logic [ACCW-1:0] rd_data;
  logic            rd_valid;
  logic [CW:0]     issue_cnt;
  logic [CW-1:0]   out_cnt;

  logic            in_fire;
  logic            out_fire;
  logic            advance;
  logic            issue;
  logic            frame_done;
  logic            emit_done;
  logic            rd_en;
  logic [CW-1:0]   rd_addr;
  logic [ACCW-1:0] wr_data;
  logic [PRODW-1:0] prod;
  logic            unused_prod;

  assign in_fire    = in_ready & reluRes_V_V_TVALID;
  assign out_fire   = out_valid & poolRes_V_V_TREADY;
  assign advance    = ~out_valid | poolRes_V_V_TREADY;
  assign issue      = (state == EMIT) && (issue_cnt != CH_COUNT) && (~rd_valid | advance);
  assign frame_done = in_fire && (ch == CH_LAST) && (pix == PIX_LAST);
  assign emit_done  = out_fire && (out_cnt == CH_LAST);

  // One read port shared by the accumulate read and the emit read; the states never overlap.
  assign rd_en   = in_fire | issue;
  assign rd_addr = (state == EMIT) ? issue_cnt[CW-1:0] : ch;

  // Pixel 0 overwrites, so the memory never needs clearing between frames.
  assign wr_data = s1_first ? ACCW'(s1_data) : rd_data + ACCW'(s1_data);

  assign prod        = {{(PRODW - ACCW){1'b0}}, rd_data} * RECIP_W + ROUND_W;
  assign unused_prod = ^{prod[SHIFT-1:0], prod[PRODW-1:SHIFT+8]};

  // Sync-read, sync-write accumulator memory with a same-address bypass.
  always_ff @(posedge ap_clk) begin
    if (s1_valid) begin
      acc_mem[s1_ch] <= wr_data;
    end
    if (rd_en) begin
      if (s1_valid && (s1_ch == rd_addr)) begin
        rd_data <= wr_data;
      end else begin
        rd_data <= acc_mem[rd_addr];
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state     <= ACCUM;
      in_ready  <= 1'b0;
      ch        <= '0;
      pix       <= '0;
      s1_valid  <= 1'b0;
      s1_first  <= 1'b0;
      s1_ch     <= '0;
      s1_data   <= '0;
      rd_valid  <= 1'b0;
      issue_cnt <= '0;
      out_cnt   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      s1_valid <= in_fire;
      if (in_fire) begin
        s1_ch    <= ch;
        s1_data  <= reluRes_V_V_TDATA;
        s1_first <= (pix == '0);
      end

      case (state)
        ACCUM: begin
          in_ready <= ~frame_done;
          if (in_fire) begin
            if (ch == CH_LAST) begin
              ch  <= '0;
              pix <= (pix == PIX_LAST) ? '0 : pix + PW'(1);
            end else begin
              ch <= ch + CW'(1);
            end
          end
          if (frame_done) begin
            state <= EMIT;
          end
        end

        default: begin
          if (issue) begin
            issue_cnt <= issue_cnt + (CW + 1)'(1);
            rd_valid  <= 1'b1;
          end else if (advance) begin
            rd_valid <= 1'b0;
          end
          // The output register only moves when empty or being accepted, which keeps it stable under stall.
          if (advance) begin
            out_valid <= rd_valid;
            if (rd_valid) begin
              out_data <= prod[SHIFT+7:SHIFT];
            end
          end
          if (out_fire) begin
            out_cnt <= out_cnt + CW'(1);
          end
          if (emit_done) begin
            state     <= ACCUM;
            in_ready  <= 1'b1;
            issue_cnt <= '0;
            out_cnt   <= '0;
          end
        end
      endcase
    end
  end

  assign reluRes_V_V_TREADY = in_ready;
  assign poolRes_V_V_TDATA  = out_data;
  assign poolRes_V_V_TVALID = out_valid;

endmodule

// File: tb/tb_layer13_global_avgpool.sv
// tb/tb_layer13_global_avgpool.sv - bench for layer13_global_avgpool
// Reduced channel count keeps each frame short; pixel count and reciprocal stay at their real values.
module tb_layer13_global_avgpool;

  localparam int CH    = 16;
  localparam int CW    = 4;
  localparam int PIX   = 49;
  localparam int PW    = 6;
  localparam int ACCW  = 14;
  localparam int RECIP = 1337;
  localparam int SHIFT = 16;
  localparam int LIMIT = 40000;
  localparam int NVEC  = 7;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] o_data;
  logic       o_valid;
  logic       out_ready = 1'b0;

  always #5 clk = ~clk;

  layer13_global_avgpool #(
    .CH(CH), .CW(CW), .PIX(PIX), .PW(PW), .ACCW(ACCW), .RECIP(RECIP), .SHIFT(SHIFT)
  ) dut (
    .ap_clk             (clk),
    .ap_rst_n           (rst_n),
    .reluRes_V_V_TDATA  (in_data),
    .reluRes_V_V_TVALID (in_valid),
    .reluRes_V_V_TREADY (in_ready),
    .poolRes_V_V_TDATA  (o_data),
    .poolRes_V_V_TVALID (o_valid),
    .poolRes_V_V_TREADY (out_ready)
  );

  // mode: 0 constant cval, 1 channel index mod 256, 2 channel 0 = pixel index, 3 random
  typedef struct {
    int mode;
    int cval;
    int gap;
    int rdy;
  } vec_t;

  vec_t       vecs [NVEC];
  int         exp_q[$];
  int         sums [CH];
  int         n_vec = 0;
  int         n_bad = 0;
  int         cyc = 0;
  int         rdy_pct = 100;
  bit         prev_stall = 0;
  logic [7:0] prev_data = '0;
  bit         lat_armed = 0;
  int         lat_cnt = 0;

  function automatic int expected_avg(input int s);
    longint t;
    t = longint'(s) * RECIP + (longint'(1) << (SHIFT - 1));
    return int'((t >> SHIFT) & 255);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic monitor(input logic ordy);
    int e;
    chk("in_ready_vs_phase", int'(in_ready), (exp_q.size() == 0) ? 1 : 0);
    if (lat_armed) begin
      lat_cnt++;
      if (o_valid) begin
        chk("first_out_latency_le4", (lat_cnt <= 4) ? 1 : 0, 1);
        lat_armed = 0;
      end
    end
    if (prev_stall) begin
      chk("stall_hold", int'({o_valid, o_data}), int'({1'b1, prev_data}));
    end
    if (o_valid && ordy) begin
      if (exp_q.size() == 0) begin
        chk("spurious_output", int'(o_data), -1);
      end else begin
        e = exp_q.pop_front();
        chk("out_data", int'(o_data), e);
      end
    end
    prev_stall = o_valid && !ordy;
    prev_data  = o_data;
  endtask

  task automatic cycle(input logic v, input logic [7:0] d, output bit acc);
    logic ordy;
    @(negedge clk);
    cyc++;
    if (cyc > LIMIT) begin
      $display("FAIL timeout: cycles %0d exceeded %0d", cyc, LIMIT);
      $fatal(1, "bench timed out");
    end
    ordy      = ($urandom_range(0, 99) < rdy_pct);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    #1;
    acc = v && in_ready;
    if (rst_n) monitor(ordy);
  endtask

  task automatic run_frame(input int mode, input int cval, input int gap, input int rdy,
                           input int stop_at);
    bit acc;
    int val;
    int n;
    n = 0;
    for (int c = 0; c < CH; c++) sums[c] = 0;
    for (int p = 0; p < PIX; p++) begin
      for (int c = 0; c < CH; c++) begin
        if (stop_at >= 0 && n == stop_at) return;
        case (mode)
          0:       val = cval;
          1:       val = c % 256;
          2:       val = (c == 0) ? p : 0;
          default: val = int'($urandom_range(0, 255));
        endcase
        acc = 0;
        while (!acc) begin
          if (int'($urandom_range(0, 99)) < gap)
            cycle(1'b0, 8'($urandom_range(0, 255)), acc);
          else
            cycle(1'b1, 8'(val), acc);
        end
        sums[c] += val;
        n++;
      end
    end
    for (int c = 0; c < CH; c++) exp_q.push_back(expected_avg(sums[c]));
    lat_armed = 1;
    lat_cnt   = 0;
    rdy_pct   = rdy;
  endtask

  initial begin
    bit a;
    vecs[0] = '{0, 255, 0, 100};
    vecs[1] = '{1, 0, 0, 100};
    vecs[2] = '{2, 0, 0, 100};
    vecs[3] = '{3, 0, 0, 30};
    vecs[4] = '{0, 10, 30, 100};
    vecs[5] = '{0, 3, 0, 100};
    vecs[6] = '{3, 0, 20, 50};

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_in_ready", int'(in_ready), 0);
    chk("reset_out_valid", int'(o_valid), 0);
    chk("reset_out_data", int'(o_data), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b0, 8'd0, a);
    chk("ready_after_release", int'(in_ready), 1);

    for (int v = 0; v < NVEC; v++) begin
      run_frame(vecs[v].mode, vecs[v].cval, vecs[v].gap, vecs[v].rdy, -1);
    end

    // Partial frame cut by reset: nothing of it may surface later.
    run_frame(0, 77, 0, 100, 300);
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("midreset_in_ready", int'(in_ready), 0);
    chk("midreset_out_valid", int'(o_valid), 0);
    chk("midreset_out_data", int'(o_data), 0);
    exp_q.delete();
    prev_stall = 0;
    lat_armed  = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_frame(0, 7, 0, 100, -1);

    for (int i = 0; i < 4 * CH + 50 && exp_q.size() > 0; i++) cycle(1'b0, 8'd0, a);
    chk("drain_empty", exp_q.size(), 0);
    cycle(1'b0, 8'd0, a);
    chk("final_in_ready", int'(in_ready), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
